// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: FSM state encoding and frame format.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   localparam int DATA_BITS = 8;
   localparam int STOP_BITS = 1;

endpackage

// File: rtl/tx_fifo.sv
// Transmit byte buffer: first-word-fall-through FIFO, power-of-two depth, registered count.
module tx_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (PTR_W + 1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // NOTE: sequential state is written with <= so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage is not reset; the pointers and count alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small input FIFO; tx comes straight from a flop, idle high.
module uart_tx #(
   parameter int CLKS_PER_BIT = 434,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx,
   output logic       busy,
   output logic       overflow
);

   import uart_pkg::*;

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] baud_q, baud_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic             tx_q, tx_d;
   logic             busy_tail_q;
   logic             overflow_q;

   logic             fifo_pop;
   logic             fifo_full;
   logic             fifo_empty;
   logic [7:0]       fifo_dout;
   logic [PTR_W:0]   fifo_count;
   logic             accept;
   logic             bit_end;

   assign tx_ready = !fifo_full;
   assign accept   = tx_valid && tx_ready;
   assign bit_end  = (baud_q == CNT_MAX);

   tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (accept),
      .pop     (fifo_pop),
      .din     (tx_data),
      .dout    (fifo_dout),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_d  = state_q;
      baud_d   = bit_end ? '0 : baud_q + 1'b1;
      bit_d    = bit_q;
      shift_d  = shift_q;
      fifo_pop = 1'b0;
      tx_d     = 1'b1;

      case (state_q)
         IDLE: begin
            baud_d = '0;
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               shift_d  = fifo_dout;
               state_d  = START;
            end
         end
         START: begin
            tx_d = 1'b0;
            if (bit_end) begin
               bit_d   = '0;
               state_d = DATA;
            end
         end
         DATA: begin
            tx_d = shift_q[bit_q];
            if (bit_end) begin
               if (bit_q == 3'(DATA_BITS - 1)) begin
                  bit_d   = '0;
                  state_d = STOP;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end
         STOP: begin
            if (bit_end) begin
               if (bit_q != 3'(STOP_BITS - 1)) begin
                  bit_d = bit_q + 1'b1;
               end else if (!fifo_empty) begin
                  // Chain straight into the next start bit; baud_d has already wrapped to 0.
                  bit_d    = '0;
                  fifo_pop = 1'b1;
                  shift_d  = fifo_dout;
                  state_d  = START;
               end else begin
                  bit_d   = '0;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         baud_q      <= '0;
         bit_q       <= '0;
         shift_q     <= '0;
         tx_q        <= 1'b1;
         busy_tail_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         baud_q      <= baud_d;
         bit_q       <= bit_d;
         shift_q     <= shift_d;
         tx_q        <= tx_d;
         busy_tail_q <= (state_q != IDLE);
         overflow_q  <= overflow_q || (tx_valid && !tx_ready);
      end
   end

   // tx lags the FSM by one cycle, so busy_tail_q covers the last stop-bit cycle on the line.
   assign busy     = (state_q != IDLE) || (fifo_count != '0) || busy_tail_q;
   assign tx       = tx_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_uart_tx;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;

   typedef struct {
      logic [7:0] data;
      logic [9:0] frame;   // [0]=start, [8:1]=data LSB first, [9]=stop
   } vec_t;

   logic       clk      = 1'b0;
   logic       reset_n  = 1'b1;
   logic [7:0] tx_data  = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic       tx;
   logic       busy;
   logic       overflow;

   int total = 0;
   int bad   = 0;

   uart_tx #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .tx       (tx),
      .busy     (busy),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   // Serial line receiver: samples mid-bit on the falling edge.
   logic [7:0] rx_q[$];
   int         rx_start[$];
   int         frame_err  = 0;
   int         cyc        = 0;
   logic       mon_active = 1'b0;
   int         mon_k      = 0;
   logic [7:0] mon_sh     = 8'h00;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (!reset_n) begin
         mon_active = 1'b0;
      end else if (!mon_active) begin
         if (tx === 1'b0) begin
            mon_active = 1'b1;
            mon_k      = 0;
            mon_sh     = 8'h00;
            rx_start.push_back(cyc);
         end
      end else begin
         mon_k++;
         if (mon_k >= 6 && mon_k <= 34 && (mon_k % 4) == 2) mon_sh[(mon_k - 6) / 4] = tx;
         if (mon_k == 38) begin
            rx_q.push_back(mon_sh);
            if (tx !== 1'b1) frame_err++;
         end
         if (mon_k == 39) mon_active = 1'b0;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (busy && n < budget) begin
         tick();
         n++;
      end
      check("wait_idle", busy, 1'b0);
   endtask

   // Push one byte into an idle transmitter and check the line edge by edge.
   task automatic send_check(input vec_t v);
      logic exp_bit;
      wait_idle(200);
      tx_data  = v.data;
      tx_valid = 1'b1;
      tick();
      tx_valid = 1'b0;
      tx_data  = ~v.data;
      check("ready_after_push", tx_ready, 1'b1);
      check("busy_after_push", busy, 1'b1);
      for (int e = 1; e <= 42; e++) begin
         tick();
         exp_bit = (e >= 2 && e <= 41) ? v.frame[(e - 2) / 4] : 1'b1;
         check($sformatf("tx_%02h_e%0d", v.data, e), tx, exp_bit);
         if (e == 41) check($sformatf("busy_%02h_e41", v.data), busy, 1'b1);
         if (e == 42) check($sformatf("busy_%02h_e42", v.data), busy, 1'b0);
      end
      check($sformatf("rx_%02h", v.data), rx_q[rx_q.size() - 1], v.data);
   endtask

   vec_t vecs[6];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   base;
      int   sz;
      int   lows;
      logic exp_bit;

      vecs[0] = '{data: 8'hA5, frame: 10'b1_1010_0101_0};
      vecs[1] = '{data: 8'h00, frame: 10'b1_0000_0000_0};
      vecs[2] = '{data: 8'hFF, frame: 10'b1_1111_1111_0};
      vecs[3] = '{data: 8'h3C, frame: 10'b1_0011_1100_0};
      vecs[4] = '{data: 8'h81, frame: 10'b1_1000_0001_0};
      vecs[5] = '{data: 8'h5A, frame: 10'b1_0101_1010_0};

      // Reset values, observed before any clock edge.
      #2 reset_n = 1'b0;
      #1;
      check("rst_tx", tx, 1'b1);
      check("rst_ready", tx_ready, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_overflow", overflow, 1'b0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;

      // Single frames, starting with the first edge after reset release.
      for (int i = 0; i < 6; i++) send_check(vecs[i]);

      // Back-to-back frames with no idle gap.
      wait_idle(200);
      tx_data  = 8'h00;
      tx_valid = 1'b1;
      tick();
      tx_data = 8'hFF;
      tick();
      tx_valid = 1'b0;
      for (int e = 2; e <= 82; e++) begin
         tick();
         if (e <= 41)      exp_bit = vecs[1].frame[(e - 2) / 4];
         else if (e <= 81) exp_bit = vecs[2].frame[(e - 42) / 4];
         else              exp_bit = 1'b1;
         check($sformatf("b2b_tx_e%0d", e), tx, exp_bit);
         if (e == 81) check("b2b_busy_e81", busy, 1'b1);
         if (e == 82) check("b2b_busy_e82", busy, 1'b0);
      end
      sz = rx_start.size();
      check("b2b_gap", rx_start[sz - 1] - rx_start[sz - 2], 40);
      check("b2b_rx0", rx_q[rx_q.size() - 2], 8'h00);
      check("b2b_rx1", rx_q[rx_q.size() - 1], 8'hFF);

      // Overflow: six pushes on consecutive edges while idle.
      wait_idle(200);
      base = rx_q.size();
      for (int k = 0; k < 6; k++) begin
         check($sformatf("ovf_ready_k%0d", k), tx_ready, (k < 5) ? 1'b1 : 1'b0);
         check($sformatf("ovf_flag_k%0d", k), overflow, 1'b0);
         tx_data  = 8'(8'h11 * (k + 1));
         tx_valid = 1'b1;
         tick();
      end
      tx_valid = 1'b0;
      check("ovf_flag_set", overflow, 1'b1);
      wait_idle(5 * 40 + 20);
      check("ovf_rx_count", rx_q.size() - base, 5);
      for (int k = 0; k < 5; k++)
         check($sformatf("ovf_rx_%0d", k), rx_q[base + k], 8'(8'h11 * (k + 1)));

      // Full FIFO with tx_valid held across the stop-bit expiry.
      wait_idle(200);
      base = rx_q.size();
      for (int k = 0; k < 5; k++) begin
         tx_data  = 8'(8'hA0 + k);
         tx_valid = 1'b1;
         tick();
      end
      tx_valid = 1'b0;
      for (int e = 5; e <= 40; e++) tick();
      check("sim_ready_full", tx_ready, 1'b0);
      tx_data  = 8'h77;
      tx_valid = 1'b1;
      tick();
      check("sim_ready_after_pop", tx_ready, 1'b1);
      tick();
      tx_valid = 1'b0;
      check("sim_ready_refull", tx_ready, 1'b0);
      wait_idle(6 * 40 + 20);
      check("sim_rx_count", rx_q.size() - base, 6);
      for (int k = 0; k < 5; k++)
         check($sformatf("sim_rx_%0d", k), rx_q[base + k], 8'(8'hA0 + k));
      check("sim_rx_last", rx_q[base + 5], 8'h77);

      // Reset during data bit 3 of 0x3C with a second byte queued.
      wait_idle(200);
      base = rx_q.size();
      tx_data  = 8'h3C;
      tx_valid = 1'b1;
      tick();
      tx_data = 8'h99;
      tick();
      tx_valid = 1'b0;
      for (int e = 2; e <= 19; e++) tick();
      check("rst3_tx_before", tx, 1'b1);
      check("rst3_busy_before", busy, 1'b1);
      reset_n = 1'b0;
      #1;
      check("rst3_tx_async", tx, 1'b1);
      check("rst3_busy_async", busy, 1'b0);
      check("rst3_ready_async", tx_ready, 1'b1);
      check("rst3_overflow_cleared", overflow, 1'b0);
      tick();
      tick();
      reset_n = 1'b1;
      check("rst3_busy_after", busy, 1'b0);
      check("rst3_ready_after", tx_ready, 1'b1);
      lows = 0;
      for (int n = 0; n < 100; n++) begin
         tick();
         if (tx !== 1'b1) lows++;
      end
      check("rst3_line_quiet", lows, 0);
      check("rst3_no_rx", rx_q.size() - base, 0);

      // Reset during the start bit, where tx is low.
      tx_data  = 8'hC3;
      tx_valid = 1'b1;
      tick();
      tx_valid = 1'b0;
      tick();
      tick();
      tick();
      check("rst0_tx_low", tx, 1'b0);
      reset_n = 1'b0;
      #1;
      check("rst0_tx_async", tx, 1'b1);
      check("rst0_busy_async", busy, 1'b0);
      tick();
      tick();
      reset_n = 1'b1;

      // Transfer accepted on the first edge after release.
      send_check(vecs[4]);
      check("frame_err", frame_err, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
